// File: rtl/trace_seq_pkg.sv
// rtl/trace_seq_pkg.sv - shared encodings for the trace trigger sequencer
package trace_seq_pkg;

    localparam int STATE_W     = 2;
    localparam int pTRIG_LEN_W = 8;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRE  = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/trace_hit_counter.sv
// rtl/trace_hit_counter.sv - 8-bit saturating per-rule hit counter
module trace_hit_counter (
    input  logic       trace_clk,
    input  logic       reset_i,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] count
);

    always_ff @(posedge trace_clk or posedge reset_i) begin
        if (reset_i) begin
            count <= 8'd0;
        end else if (clr) begin
            count <= 8'd0;
        end else if (inc && count != 8'hFF) begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/trace_trig_sequencer.sv
// rtl/trace_trig_sequencer.sv - ordered multi-stage trigger sequencer with hit counters
module trace_trig_sequencer
    import trace_seq_pkg::*;
#(
    parameter int pMATCH_RULES  = 8,
    parameter int pSTAGES       = 4,
    parameter int pWINDOW_WIDTH = 16,
    parameter int pRULE_IDX_W   = 3
) (
    input  logic                              trace_clk,
    input  logic                              reset_i,
    input  logic [pMATCH_RULES-1:0]           I_matching_pattern,
    input  logic                              I_synchronized,
    input  logic                              I_arm,
    input  logic [2:0]                        I_num_stages,
    input  logic [pSTAGES*pRULE_IDX_W-1:0]    I_stage_rule,
    input  logic [pSTAGES*pWINDOW_WIDTH-1:0]  I_stage_window,
    input  logic [7:0]                        I_trig_length,
    output logic                              O_trigger,
    output logic [1:0]                        O_state,
    output logic [$clog2(pSTAGES)-1:0]        O_stage,
    output logic [pMATCH_RULES*8-1:0]         O_trace_count
);

    localparam int STAGE_W = $clog2(pSTAGES);
    localparam logic [STAGE_W-1:0]       STAGE_ONE = 1;
    localparam logic [pWINDOW_WIDTH-1:0] WIN_ONE   = 1;
    localparam logic [pTRIG_LEN_W-1:0]   LEN_ONE   = 1;

    logic                                    arm_q;
    logic                                    arm_prev;
    logic                                    arm_rise;
    seq_state_t                              state;
    logic [STAGE_W-1:0]                      stage;
    logic [STAGE_W-1:0]                      last_stage;
    logic [pSTAGES-1:0][pRULE_IDX_W-1:0]     rule_q;
    logic [pSTAGES-1:0][pWINDOW_WIDTH-1:0]   window_q;
    logic [pTRIG_LEN_W-1:0]                  len_q;
    logic [pTRIG_LEN_W-1:0]                  pulse_cnt;
    logic [pWINDOW_WIDTH-1:0]                win_cnt;
    logic                                    trigger;

    logic [2:0]                              nstg_c;
    logic [STAGE_W-1:0]                      last_c;
    logic [pWINDOW_WIDTH-1:0]                win_cur;
    logic                                    match_cur;
    logic                                    match_first;
    logic                                    win_active;
    logic                                    timeout;

    assign arm_rise = arm_q & ~arm_prev;

    always_comb begin
        nstg_c = I_num_stages;
        if (I_num_stages == 3'd0) begin
            nstg_c = 3'd1;
        end else if (int'(I_num_stages) > pSTAGES) begin
            nstg_c = 3'(pSTAGES);
        end
        last_c = STAGE_W'(nstg_c - 3'd1);
    end

    // A match at the current stage always beats a window expiry in the same cycle.
    always_comb begin
        win_cur     = window_q[stage];
        match_cur   = I_matching_pattern[rule_q[stage]];
        match_first = I_matching_pattern[rule_q[0]];
        win_active  = (stage != '0) && (win_cur != '0);
        timeout     = win_active && !match_cur && (win_cnt == win_cur - WIN_ONE);
    end

    always_ff @(posedge trace_clk or posedge reset_i) begin
        if (reset_i) begin
            arm_q      <= 1'b0;
            arm_prev   <= 1'b0;
            state      <= IDLE;
            stage      <= '0;
            last_stage <= '0;
            rule_q     <= '0;
            window_q   <= '0;
            len_q      <= '0;
            pulse_cnt  <= '0;
            win_cnt    <= '0;
            trigger    <= 1'b0;
        end else begin
            arm_q    <= I_arm;
            arm_prev <= arm_q;
            if (!arm_q) begin
                state   <= IDLE;
                stage   <= '0;
                win_cnt <= '0;
                trigger <= 1'b0;
            end else if (arm_rise) begin
                // Config is only sampled here, so the usb_clk-side registers may be quasi-static.
                last_stage <= last_c;
                rule_q     <= I_stage_rule;
                window_q   <= I_stage_window;
                len_q      <= (I_trig_length == 8'd0) ? LEN_ONE : I_trig_length;
                state      <= ARMED;
                stage      <= '0;
                win_cnt    <= '0;
                trigger    <= 1'b0;
            end else begin
                case (state)
                    ARMED: begin
                        if (!I_synchronized) begin
                            stage   <= '0;
                            win_cnt <= '0;
                        end else if (match_cur) begin
                            if (stage == last_stage) begin
                                state     <= FIRE;
                                trigger   <= 1'b1;
                                pulse_cnt <= len_q;
                            end else begin
                                stage   <= stage + STAGE_ONE;
                                win_cnt <= '0;
                            end
                        end else if (timeout) begin
                            win_cnt <= '0;
                            stage   <= match_first ? STAGE_ONE : '0;
                        end else if (win_active) begin
                            win_cnt <= win_cnt + WIN_ONE;
                        end
                    end
                    FIRE: begin
                        pulse_cnt <= pulse_cnt - LEN_ONE;
                        if (pulse_cnt == LEN_ONE) begin
                            state   <= DONE;
                            trigger <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign O_trigger = trigger;
    assign O_state   = state;
    assign O_stage   = stage;

    for (genvar r = 0; r < pMATCH_RULES; r++) begin : g_hit
        trace_hit_counter u_hit (
            .trace_clk (trace_clk),
            .reset_i   (reset_i),
            .clr       (arm_rise),
            .inc       ((state != IDLE) && I_synchronized && I_matching_pattern[r]),
            .count     (O_trace_count[r*8 +: 8])
        );
    end

endmodule

// File: tb/tb_trace_trig_sequencer.sv
// tb/tb_trace_trig_sequencer.sv - self-checking bench for trace_trig_sequencer
module tb_trace_trig_sequencer;

    logic        trace_clk = 1'b0;
    logic        reset_i;
    logic [7:0]  pat;
    logic        sync;
    logic        arm;
    logic [2:0]  nst_in;
    logic [11:0] rule_in;
    logic [63:0] win_in;
    logic [7:0]  len_in;
    logic        O_trigger;
    logic [1:0]  O_state;
    logic [1:0]  O_stage;
    logic [63:0] O_trace_count;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model: stage progress tracked as cycle-number gaps, not counters
    int m_st, m_stg, m_tlast, m_rem, m_cyc;
    bit m_trig, m_aq, m_ap;
    int m_cnt[8];
    int c_n, c_len;
    int c_rule[4];
    int c_win[4];

    typedef struct {
        logic [2:0] nst;
        int r0, r1, win, gap, len;
        int exp_first, exp_width, exp_state;
    } vec_t;
    vec_t tbl[10];

    always #5 trace_clk = ~trace_clk;

    trace_trig_sequencer dut (
        .trace_clk          (trace_clk),
        .reset_i            (reset_i),
        .I_matching_pattern (pat),
        .I_synchronized     (sync),
        .I_arm              (arm),
        .I_num_stages       (nst_in),
        .I_stage_rule       (rule_in),
        .I_stage_window     (win_in),
        .I_trig_length      (len_in),
        .O_trigger          (O_trigger),
        .O_state            (O_state),
        .O_stage            (O_stage),
        .O_trace_count      (O_trace_count)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_st = 0; m_stg = 0; m_tlast = 0; m_rem = 0;
        m_trig = 0; m_aq = 0; m_ap = 0;
        c_n = 1; c_len = 1;
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
        for (int k = 0; k < 4; k++) begin c_rule[k] = 0; c_win[k] = 0; end
    endtask

    function automatic logic [63:0] m_counts();
        logic [63:0] v;
        for (int r = 0; r < 8; r++) v[r*8 +: 8] = 8'(m_cnt[r]);
        return v;
    endfunction

    task automatic m_advance();
        if (m_stg == c_n - 1) begin
            m_st = 2; m_trig = 1; m_rem = c_len;
        end else begin
            m_stg++; m_tlast = m_cyc;
        end
    endtask

    task automatic m_clock();
        bit rise;
        int ns;
        rise = m_aq && !m_ap;
        if (rise) begin
            for (int r = 0; r < 8; r++) m_cnt[r] = 0;
        end else if (m_st != 0 && sync) begin
            for (int r = 0; r < 8; r++) if (pat[r] && m_cnt[r] < 255) m_cnt[r]++;
        end
        if (!m_aq) begin
            m_st = 0; m_trig = 0; m_stg = 0;
        end else if (rise) begin
            ns = int'(nst_in);
            if (ns == 0) ns = 1;
            if (ns > 4) ns = 4;
            c_n = ns;
            for (int k = 0; k < 4; k++) begin
                c_rule[k] = int'(rule_in[k*3 +: 3]);
                c_win[k]  = int'(win_in[k*16 +: 16]);
            end
            c_len = (len_in == 8'd0) ? 1 : int'(len_in);
            m_st = 1; m_stg = 0; m_trig = 0;
        end else if (m_st == 1) begin
            if (!sync) m_stg = 0;
            else if (pat[c_rule[m_stg]]) m_advance();
            else if (m_stg > 0 && c_win[m_stg] != 0 && m_cyc - m_tlast >= c_win[m_stg]) begin
                m_stg = 0;
                if (pat[c_rule[0]]) m_advance();
            end
        end else if (m_st == 2) begin
            m_rem--;
            if (m_rem == 0) begin m_st = 3; m_trig = 0; end
        end
        m_ap = m_aq;
        m_aq = arm;
        m_cyc++;
    endtask

    task automatic check_all();
        chk("model_trigger", O_trigger, m_trig);
        chk("model_state", O_state, m_st);
        chk("model_stage", O_stage, m_stg);
        chk("model_counts", O_trace_count, m_counts());
    endtask

    task automatic step();
        m_clock();
        @(posedge trace_clk);
        #1;
        check_all();
    endtask

    task automatic arm_cfg(input int nst, input int r0, input int r1, input int w1, input int len);
        pat = 8'd0;
        sync = 1'b1;
        arm = 1'b0;
        step(); step();
        nst_in  = 3'(nst);
        rule_in = {3'd0, 3'd0, 3'(r1), 3'(r0)};
        win_in  = {16'd0, 16'd0, 16'(w1), 16'd0};
        len_in  = 8'(len);
        arm = 1'b1;
        step(); step();
        chk("armed_state", O_state, 1);
    endtask

    initial begin
        tbl[0] = '{3'd2, 3, 5, 0, 10, 4, 10, 4, 3};
        tbl[1] = '{3'd2, 3, 5, 6,  8, 4, -1, 0, 1};
        tbl[2] = '{3'd2, 3, 5, 6,  4, 4,  4, 4, 3};
        tbl[3] = '{3'd2, 3, 5, 6,  6, 4,  6, 4, 3};
        tbl[4] = '{3'd2, 3, 5, 6,  7, 4, -1, 0, 1};
        tbl[5] = '{3'd2, 3, 5, 0,  3, 0,  3, 1, 3};
        tbl[6] = '{3'd0, 3, 5, 0,  5, 2,  0, 2, 3};
        tbl[7] = '{3'd7, 1, 2, 0,  2, 3, -1, 0, 1};
        tbl[8] = '{3'd2, 4, 6, 1,  1, 1,  1, 1, 3};
        tbl[9] = '{3'd2, 4, 6, 1,  2, 1, -1, 0, 1};

        reset_i = 1'b1; arm = 1'b0; sync = 1'b1; pat = 8'd0;
        nst_in = 3'd0; rule_in = '0; win_in = '0; len_in = 8'd0;
        m_cyc = 0;
        m_reset();
        @(posedge trace_clk); #1;
        check_all();
        chk("reset_trigger", O_trigger, 0);
        chk("reset_counts", O_trace_count, 0);
        reset_i = 1'b0;

        foreach (tbl[i]) begin
            int first, width;
            arm_cfg(int'(tbl[i].nst), tbl[i].r0, tbl[i].r1, tbl[i].win, tbl[i].len);
            first = -1; width = 0;
            for (int k = 0; k <= tbl[i].gap + tbl[i].len + 4; k++) begin
                pat = (k == 0) ? 8'(1 << tbl[i].r0) : (k == tbl[i].gap) ? 8'(1 << tbl[i].r1) : 8'd0;
                step();
                if (O_trigger) begin
                    if (first < 0) first = k;
                    width++;
                end
            end
            pat = 8'd0;
            chk($sformatf("vec%0d_first", i), 64'(first), 64'(tbl[i].exp_first));
            chk($sformatf("vec%0d_width", i), 64'(width), 64'(tbl[i].exp_width));
            chk($sformatf("vec%0d_state", i), O_state, 64'(tbl[i].exp_state));
        end

        // expiry cycle that also carries the stage-0 rule restarts at stage 1
        arm_cfg(2, 3, 5, 6, 2);
        pat = 8'h08; step();
        pat = 8'h00; repeat (5) step();
        pat = 8'h08; step();
        chk("timeout_rule0_stage", O_stage, 1);
        pat = 8'h20; step();
        chk("timeout_rule0_fire", O_trigger, 1);
        pat = 8'h00;

        arm_cfg(2, 3, 5, 0, 2);
        pat = 8'h08; step();
        chk("sync_pre_stage", O_stage, 1);
        pat = 8'h00; sync = 1'b0; step();
        chk("sync_loss_stage", O_stage, 0);
        sync = 1'b1; step();

        arm_cfg(2, 3, 5, 0, 8);
        pat = 8'h08; step();
        pat = 8'h20; step();
        chk("fire_latency", O_trigger, 1);
        pat = 8'h00; arm = 1'b0; step(); step();
        chk("disarm_trigger", O_trigger, 0);
        chk("disarm_state", O_state, 0);

        arm_cfg(2, 3, 5, 0, 20);
        pat = 8'h08; step();
        pat = 8'h20; step();
        pat = 8'h00; step();
        #3 reset_i = 1'b1;
        m_reset();
        #1;
        chk("async_reset_trigger", O_trigger, 0);
        chk("async_reset_state", O_state, 0);
        chk("async_reset_counts", O_trace_count, 0);
        arm = 1'b0;
        reset_i = 1'b0;
        step();

        arm_cfg(1, 7, 7, 0, 1);
        pat = 8'h04;
        repeat (300) step();
        chk("sat_rule2", O_trace_count[23:16], 255);
        step();
        chk("sat_hold", O_trace_count, 64'h0000_0000_00ff_0000);
        pat = 8'h00; arm = 1'b0; step(); step();
        chk("disarm_hold_counts", O_trace_count[23:16], 255);
        arm = 1'b1; step(); step();
        chk("rearm_clear_counts", O_trace_count, 0);

        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 59) == 0) arm = ~arm;
            if (!arm) begin
                nst_in  = 3'($urandom_range(0, 7));
                rule_in = 12'($urandom);
                for (int k = 0; k < 4; k++) win_in[k*16 +: 16] = 16'($urandom_range(0, 6));
                len_in  = 8'($urandom_range(0, 5));
            end
            sync = ($urandom_range(0, 39) != 0);
            pat  = 8'($urandom & $urandom & $urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
